// File: rtl/alu_pkg.sv
// alu_pkg: function codes, issue FSM states and decode helpers shared by the
// TotalALU issue stage and the TotalALU control logic.
package alu_pkg;

  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issue_state_e;

  function automatic logic is_legal_funct(input logic [5:0] f);
    logic ok;
    case (f)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
      FN_SRL, FN_MULTU, FN_MFHI, FN_MFLO: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_mul(input logic [5:0] f);
    return (f == FN_MULTU);
  endfunction

  // Codes that touch HI/LO and therefore must wait for a running multiply.
  function automatic logic uses_hilo(input logic [5:0] f);
    return (f == FN_MULTU) || (f == FN_MFHI) || (f == FN_MFLO);
  endfunction

endpackage

// File: rtl/alu_issue_cnt.sv
// alu_issue_cnt: loadable down-counter that stops at zero, with a zero flag.
// A load in the same cycle as a decrement wins.
module alu_issue_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, else decrement while nonzero.
  always_comb begin
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation at a time to TotalALU and returns the result.
// Optional HI/LO background interlock: define ALU_ISSUE_HILO_INTERLOCK_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        busy
);

  localparam logic [5:0] LAT_LD = 6'(ALU_LAT);

  issue_state_e state_q, state_d;
  logic [31:0]  a_q, a_d, b_q, b_d;
  logic [5:0]   funct_q, funct_d;
  logic [31:0]  out_data_q, out_data_d;
  logic         out_err_q, out_err_d;

  logic [5:0]   cnt_s, cnt_ld_val_s;
  logic         cnt_zero_s, cnt_load_s;
  logic         accept_s, in_legal_s, exec_done_s;
  logic         hilo_block_s, mul_hold_s;
  logic [31:0]  mul_a_s, mul_b_s;

  assign in_legal_s  = is_legal_funct(in_funct);
  assign accept_s    = in_valid && in_ready;
  assign exec_done_s = (state_q == ST_EXEC) && (cnt_s == 6'd1);
  assign cnt_load_s  = accept_s && in_legal_s;

`ifdef ALU_ISSUE_HILO_INTERLOCK_EN
  localparam logic [5:0] MUL_REM = 6'(MUL_CYCLES - ALU_LAT);

  logic [5:0]  mul_cnt_s;
  logic        mul_zero_s, mul_load_s;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;

  assign cnt_ld_val_s = LAT_LD;
  assign mul_load_s   = exec_done_s && is_mul(funct_q);

  alu_issue_cnt #(.W(6)) u_mul_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_load_s),
    .load_val (MUL_REM),
    .cnt      (mul_cnt_s),
    .zero     (mul_zero_s)
  );

  // Multiply operands stay on the ALU in the background after MULTU retires.
  always_comb begin
    if (mul_load_s) begin
      mul_a_d = a_q;
      mul_b_d = b_q;
    end else begin
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
    end
  end

  // Background multiply operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign mul_hold_s   = (mul_cnt_s != 6'd0);
  assign hilo_block_s = !mul_zero_s && uses_hilo(in_funct);
  assign mul_a_s      = mul_a_q;
  assign mul_b_s      = mul_b_q;
`else
  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES);

  assign cnt_ld_val_s = is_mul(in_funct) ? MUL_LD : LAT_LD;
  assign mul_hold_s   = 1'b0;
  assign hilo_block_s = 1'b0;
  assign mul_a_s      = 32'd0;
  assign mul_b_s      = 32'd0;
`endif

  alu_issue_cnt #(.W(6)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (cnt_ld_val_s),
    .cnt      (cnt_s),
    .zero     (cnt_zero_s)
  );

  // FSM state and operation/response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      funct_q    <= 6'd0;
      out_data_q <= 32'd0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      funct_q    <= funct_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  // Next-state logic; illegal codes skip EXEC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = in_legal_s ? ST_EXEC : ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_s == 6'd1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latches and result capture.
  always_comb begin
    if (accept_s) begin
      a_d        = in_a;
      b_d        = in_b;
      funct_d    = in_funct;
      out_data_d = 32'd0;
      out_err_d  = !in_legal_s;
    end else if (exec_done_s) begin
      a_d        = a_q;
      b_d        = b_q;
      funct_d    = funct_q;
      out_data_d = is_mul(funct_q) ? 32'd0 : alu_result;
      out_err_d  = 1'b0;
    end else begin
      a_d        = a_q;
      b_d        = b_q;
      funct_d    = funct_q;
      out_data_d = out_data_q;
      out_err_d  = out_err_q;
    end
  end

  // Outputs decoded from state; a background multiply owns the ALU when EXEC is idle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (mul_hold_s) begin
      alu_signal = FN_MULTU;
      alu_dataA  = mul_a_s;
      alu_dataB  = mul_b_s;
    end else begin
      alu_signal = 6'd0;
      alu_dataA  = 32'd0;
      alu_dataB  = 32'd0;
    end
    case (state_q)
      ST_IDLE: in_ready = !hilo_block_s;
      ST_EXEC: begin
        alu_signal = funct_q;
        alu_dataA  = a_q;
        alu_dataB  = b_q;
      end
      ST_RESP: out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign out_data = out_data_q;
  assign out_err  = out_err_q;
  assign busy     = (state_q != ST_IDLE) || !cnt_zero_s || mul_hold_s;

endmodule
